decoder_hold: RTL and testbench

- Sequential 3-to-8 decoder: the receiving end of the priority encoder's (code, valid) output.
- Accepts one encoded code per valid/ready handshake and drives the matching one-hot line, registered.
- Each one-hot output is held for a programmable number of cycles; the upstream handshake is back-pressured while a hold is in progress.
- Sits downstream of the priority encoder and drives select or enable fabric that needs stable one-hot pulses of fixed width.

---
 rtl/decoder_pkg.sv | 17 +
 rtl/hold_counter.sv | 29 ++
 rtl/decoder_hold.sv | 113 +++++++++++
 tb/tb_decoder_hold.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder_hold slice: FSM state encoding,
// output-width helper and hit-counter width.
package decoder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam int unsigned HIT_CNT_W = 8;

  // One-hot output width for an n-bit code.
  function automatic int unsigned num_out(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter used as the pulse-width timer. A load takes
// priority over a decrement, and the count stops at zero.
module hold_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load a new pulse width, or count down towards zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/decoder_hold.sv
// Sequential N_SEL-to-2**N_SEL decoder with a programmable hold time.
// Each accepted valid code drives a registered one-hot pulse of exactly
// HOLD cycles; upstream is back-pressured until the last hold cycle.
// Optional macro DECODER_HOLD_HIT_CNT_EN adds a saturating hit_cnt port
// counting accepted codes with in_v=1.
module decoder_hold
  import decoder_pkg::*;
#(
  parameter int unsigned N_SEL = 3,
  parameter int unsigned HOLD  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_SEL-1:0]               in_code,
  input  logic                           in_v,
  output logic [num_out(N_SEL)-1:0]      out_onehot,
  output logic                           out_valid,
  output logic                           busy
`ifdef DECODER_HOLD_HIT_CNT_EN
  ,
  output logic [HIT_CNT_W-1:0]           hit_cnt
`endif
);

  localparam int unsigned NUM_OUT = num_out(N_SEL);
  localparam int unsigned CNT_W   = (HOLD > 1) ? $clog2(HOLD) : 1;

  state_t               r_state;
  logic [NUM_OUT-1:0]   r_onehot;
  logic                 r_out_valid;
  logic [NUM_OUT-1:0]   w_decode;
  logic                 w_accept;
  logic                 w_load;
  logic                 w_zero;

  assign in_ready   = (r_state == ST_IDLE) || w_zero;
  assign w_accept   = in_valid && in_ready;
  assign w_load     = w_accept && in_v;
  assign busy       = (r_state == ST_HOLD);
  assign out_onehot = r_onehot;
  assign out_valid  = r_out_valid;

  // Plain one-hot decode of the incoming code.
  always_comb begin
    w_decode          = '0;
    w_decode[in_code] = 1'b1;
  end

  // Pulse-width timer: reloaded on every valid accept, counts down in HOLD.
  hold_counter #(
    .W (CNT_W)
  ) u_hold_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (CNT_W'(HOLD - 1)),
    .i_dec      (busy),
    .o_zero     (w_zero)
  );

  // FSM with registered one-hot/valid outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_onehot    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_onehot    <= w_decode;
            r_out_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_zero) begin
            if (w_load) begin
              r_onehot <= w_decode;
            end else begin
              r_onehot    <= '0;
              r_out_valid <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_onehot    <= '0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DECODER_HOLD_HIT_CNT_EN
  logic [HIT_CNT_W-1:0] r_hit_cnt;

  // Saturating count of accepted non-null codes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt <= '0;
    end else if (w_load && (r_hit_cnt != '1)) begin
      r_hit_cnt <= r_hit_cnt + 1'b1;
    end
  end

  assign hit_cnt = r_hit_cnt;
`endif

endmodule

// File: tb/tb_decoder_hold.sv
// Directed bench for decoder_hold: three instances with HOLD=4, 2 and 1.
module tb_decoder_hold;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // HOLD=4 instance
  logic       a_valid, a_ready, a_v, a_ov, a_busy;
  logic [2:0] a_code;
  logic [7:0] a_oh;
  // HOLD=2 instance
  logic       b_valid, b_ready, b_v, b_ov, b_busy;
  logic [2:0] b_code;
  logic [7:0] b_oh;
  // HOLD=1 instance
  logic       c_valid, c_ready, c_v, c_ov, c_busy;
  logic [2:0] c_code;
  logic [7:0] c_oh;
`ifdef DECODER_HOLD_HIT_CNT_EN
  logic [7:0] a_hits, b_hits, c_hits;
`endif

  decoder_hold #(.N_SEL(3), .HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
    .in_code(a_code), .in_v(a_v), .out_onehot(a_oh), .out_valid(a_ov),
    .busy(a_busy)
`ifdef DECODER_HOLD_HIT_CNT_EN
    , .hit_cnt(a_hits)
`endif
  );

  decoder_hold #(.N_SEL(3), .HOLD(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
    .in_code(b_code), .in_v(b_v), .out_onehot(b_oh), .out_valid(b_ov),
    .busy(b_busy)
`ifdef DECODER_HOLD_HIT_CNT_EN
    , .hit_cnt(b_hits)
`endif
  );

  decoder_hold #(.N_SEL(3), .HOLD(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_ready),
    .in_code(c_code), .in_v(c_v), .out_onehot(c_oh), .out_valid(c_ov),
    .busy(c_busy)
`ifdef DECODER_HOLD_HIT_CNT_EN
    , .hit_cnt(c_hits)
`endif
  );

  typedef struct {
    logic       valid;
    logic [2:0] code;
    logic       v;
    logic [7:0] oh;
    logic       ov;
    logic       rdy;
    logic       busy;
    logic [7:0] hits;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] b_exp_oh  [7];
  logic       b_exp_rdy [7];
  logic [2:0] b_codes   [3];
  int unsigned b_idx;
  logic        acc;
  logic [7:0]  one;

  initial begin
    a_valid = 0; a_code = 0; a_v = 0;
    b_valid = 0; b_code = 0; b_v = 0;
    c_valid = 0; c_code = 0; c_v = 0;

    // Test 1: reset for 2 cycles, then idle
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_a_oh",  {24'd0, a_oh}, 32'h00);
    chk("rst_a_ov",  {31'd0, a_ov}, 32'd0);
    chk("rst_a_rdy", {31'd0, a_ready}, 32'd1);
    chk("rst_a_busy",{31'd0, a_busy}, 32'd0);
    chk("rst_b_oh",  {24'd0, b_oh}, 32'h00);
    chk("rst_c_oh",  {24'd0, c_oh}, 32'h00);
    tick();
    chk("idle_a_oh",  {24'd0, a_oh}, 32'h00);
    chk("idle_a_rdy", {31'd0, a_ready}, 32'd1);

    // Tests 2/3 (HOLD=4): {valid, code, v, oh, ov, rdy, busy, hits}
    tbl[0]  = '{1'b1, 3'd5, 1'b1, 8'h20, 1'b1, 1'b0, 1'b1, 8'd1};
    tbl[1]  = '{1'b1, 3'd1, 1'b1, 8'h20, 1'b1, 1'b0, 1'b1, 8'd1};
    tbl[2]  = '{1'b0, 3'd0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b1, 8'd1};
    tbl[3]  = '{1'b0, 3'd0, 1'b0, 8'h20, 1'b1, 1'b1, 1'b1, 8'd1};
    tbl[4]  = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[5]  = '{1'b1, 3'd7, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[6]  = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[7]  = '{1'b1, 3'd0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'd2};
    tbl[8]  = '{1'b0, 3'd0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 8'd2};
    tbl[9]  = '{1'b0, 3'd0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 8'd2};
    tbl[10] = '{1'b0, 3'd0, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 8'd2};
    tbl[11] = '{1'b1, 3'd6, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd2};

    for (int i = 0; i < 12; i++) begin
      a_valid = tbl[i].valid;
      a_code  = tbl[i].code;
      a_v     = tbl[i].v;
      tick();
      chk($sformatf("vec%0d_oh", i),   {24'd0, a_oh},    {24'd0, tbl[i].oh});
      chk($sformatf("vec%0d_ov", i),   {31'd0, a_ov},    {31'd0, tbl[i].ov});
      chk($sformatf("vec%0d_rdy", i),  {31'd0, a_ready}, {31'd0, tbl[i].rdy});
      chk($sformatf("vec%0d_busy", i), {31'd0, a_busy},  {31'd0, tbl[i].busy});
`ifdef DECODER_HOLD_HIT_CNT_EN
      chk($sformatf("vec%0d_hits", i), {24'd0, a_hits},  {24'd0, tbl[i].hits});
`endif
    end
    a_valid = 0; a_v = 0;

    // Test 4 (HOLD=2): codes 7,0,2 with valid held high, no gap
    b_codes[0] = 3'd7; b_codes[1] = 3'd0; b_codes[2] = 3'd2;
    b_exp_oh[0] = 8'h80; b_exp_oh[1] = 8'h80; b_exp_oh[2] = 8'h01;
    b_exp_oh[3] = 8'h01; b_exp_oh[4] = 8'h04; b_exp_oh[5] = 8'h04;
    b_exp_oh[6] = 8'h00;
    b_exp_rdy[0] = 0; b_exp_rdy[1] = 1; b_exp_rdy[2] = 0; b_exp_rdy[3] = 1;
    b_exp_rdy[4] = 0; b_exp_rdy[5] = 1; b_exp_rdy[6] = 1;
    b_idx = 0;
    b_valid = 1; b_v = 1; b_code = b_codes[0];
    for (int c = 0; c < 7; c++) begin
      acc = b_valid && b_ready;
      tick();
      if (acc) b_idx++;
      chk($sformatf("b2b%0d_oh", c),  {24'd0, b_oh},    {24'd0, b_exp_oh[c]});
      chk($sformatf("b2b%0d_rdy", c), {31'd0, b_ready}, {31'd0, b_exp_rdy[c]});
      if (b_idx < 3) b_code = b_codes[b_idx];
      else b_valid = 0;
    end
    chk("b2b_accepts", b_idx, 32'd3);
`ifdef DECODER_HOLD_HIT_CNT_EN
    chk("b2b_hits", {24'd0, b_hits}, 32'd3);
`endif

    // Test 6 (HOLD=1): sweep codes 0..7 on consecutive cycles
    c_valid = 1; c_v = 1;
    for (int k = 0; k < 8; k++) begin
      c_code = 3'(k);
      chk($sformatf("sweep%0d_rdy_pre", k), {31'd0, c_ready}, 32'd1);
      tick();
      one = 8'h01;
      chk($sformatf("sweep%0d_oh", k), {24'd0, c_oh}, {24'd0, one << k});
      chk($sformatf("sweep%0d_ov", k), {31'd0, c_ov}, 32'd1);
    end
    c_valid = 0; c_v = 0;
    tick();
    chk("sweep_end_oh",  {24'd0, c_oh}, 32'h00);
    chk("sweep_end_rdy", {31'd0, c_ready}, 32'd1);
`ifdef DECODER_HOLD_HIT_CNT_EN
    chk("sweep_hits", {24'd0, c_hits}, 32'd8);
`endif

    // Test 5 (HOLD=4): asynchronous reset in the middle of a hold
    a_valid = 1; a_code = 3'd2; a_v = 1;
    tick();
    a_valid = 0; a_v = 0;
    chk("mid_pre_oh", {24'd0, a_oh}, 32'h04);
    #2 rst = 1'b1;
    #1;
    chk("mid_async_oh",   {24'd0, a_oh}, 32'h00);
    chk("mid_async_ov",   {31'd0, a_ov}, 32'd0);
    chk("mid_async_busy", {31'd0, a_busy}, 32'd0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("mid_after_oh",   {24'd0, a_oh}, 32'h00);
    chk("mid_after_rdy",  {31'd0, a_ready}, 32'd1);
    chk("mid_after_busy", {31'd0, a_busy}, 32'd0);
`ifdef DECODER_HOLD_HIT_CNT_EN
    chk("mid_after_hits", {24'd0, a_hits}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
